// File: rtl/data_bus_bridge.sv
// ============================================================================
// data_bus_bridge
//
// Purpose:
//   Sits downstream of the memory-access stage on the data side of the CPU.
//   It turns the stage's single-cycle combinational access request into a
//   registered request/acknowledge transaction on an external data bus that
//   may insert wait states. While a transaction is outstanding it asks the
//   pipeline controller to stall. The full 32-bit read word is returned; byte
//   lane extraction is left to the memory-access stage.
//
// Parameters:
//   TIMEOUT   bus cycles without ack before the transaction is aborted
//             (0 disables the timeout)
//   CNT_W     width of the timeout counter, must be able to hold TIMEOUT
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous, active-low reset
//   mem_ce_i     in   access request from the memory-access stage
//   mem_we_i     in   1 = write, 0 = read
//   mem_addr_i   in   [31:0] access address
//   mem_sel_i    in   [3:0] byte enables, bit3 = data[31:24]
//   mem_data_i   in   [31:0] store data
//   stall_i      in   pipeline held by another stage this cycle
//   flush_i      in   pipeline flush
//   mem_data_o   out  [31:0] registered read word to the memory-access stage
//   stallreq_o   out  stall request to the pipeline controller
//   bus_req_o    out  bus request
//   bus_we_o     out  bus write enable
//   bus_addr_o   out  [31:0] bus address
//   bus_sel_o    out  [3:0] bus byte enables
//   bus_wdata_o  out  [31:0] bus write data
//   bus_ack_i    in   bus acknowledge, read data valid in the same cycle
//   bus_rdata_i  in   [31:0] bus read data
//   err_o        out  one-cycle pulse after a timeout abort
// ============================================================================
module data_bus_bridge #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_data_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic [31:0] mem_data_o,
    output logic        stallreq_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic        err_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Counter value on the last BUS cycle before an abort. Only meaningful
    // when the timeout is enabled.
    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_drop;

    logic w_valid;
    logic w_drop;
    logic w_timeout;

    // An access with no byte lanes enabled is not a real access.
    assign w_valid   = mem_ce_i && (mem_sel_i != 4'b0000);
    // A flush arriving in the very cycle the bus finishes still discards it.
    assign w_drop    = r_drop || flush_i;
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == LP_CNT_LAST);

    // Stall request is combinational so the access cycle itself is held.
    // Gated by reset so nothing is requested while the bridge is held reset.
    always_comb begin
        stallreq_o = 1'b0;
        case (r_state)
            S_IDLE:  stallreq_o = rst && w_valid && !flush_i;
            S_BUS:   stallreq_o = 1'b1;
            default: stallreq_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_drop      <= 1'b0;
            mem_data_o  <= '0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_sel_o   <= '0;
            bus_wdata_o <= '0;
            err_o       <= 1'b0;
        end else begin
            err_o <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_valid && !flush_i) begin
                        bus_we_o    <= mem_we_i;
                        bus_addr_o  <= mem_addr_i;
                        bus_sel_o   <= mem_sel_i;
                        bus_wdata_o <= mem_data_i;
                        bus_req_o   <= 1'b1;
                        r_cnt       <= '0;
                        r_drop      <= 1'b0;
                        r_state     <= S_BUS;
                    end
                end

                S_BUS: begin
                    // The bus transaction always runs to completion; a flush
                    // only marks its result to be thrown away.
                    if (flush_i) begin
                        r_drop <= 1'b1;
                    end
                    if (bus_ack_i) begin
                        bus_req_o <= 1'b0;
                        if (!bus_we_o && !w_drop) begin
                            mem_data_o <= bus_rdata_i;
                        end
                        r_drop  <= 1'b0;
                        r_state <= w_drop ? S_IDLE : S_DONE;
                    end else if (w_timeout) begin
                        bus_req_o <= 1'b0;
                        err_o     <= 1'b1;
                        if (!w_drop) begin
                            mem_data_o <= '0;
                        end
                        r_drop  <= 1'b0;
                        r_state <= w_drop ? S_IDLE : S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_DONE: begin
                    // Result stays presented while the pipeline is held; any
                    // request seen here is re-evaluated from IDLE.
                    if (!(stall_i && !flush_i)) begin
                        r_state <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_bus_bridge.sv
// ============================================================================
// tb_data_bus_bridge
//
// Purpose:
//   Directed self-checking bench for data_bus_bridge. Inputs are driven 1 time
//   unit after each rising edge; outputs are checked 1 time unit later, well
//   away from the next edge. The DUT runs with TIMEOUT=4.
// ============================================================================
module tb_data_bus_bridge;

    logic        clk;
    logic        rst;
    logic        mem_ce_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_data_i;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] mem_data_o;
    logic        stallreq_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;
    logic        err_o;

    int n_cmp;
    int n_err;

    data_bus_bridge #(
        .TIMEOUT (4),
        .CNT_W   (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_ce_i    (mem_ce_i),
        .mem_we_i    (mem_we_i),
        .mem_addr_i  (mem_addr_i),
        .mem_sel_i   (mem_sel_i),
        .mem_data_i  (mem_data_i),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .mem_data_o  (mem_data_o),
        .stallreq_o  (stallreq_o),
        .bus_req_o   (bus_req_o),
        .bus_we_o    (bus_we_o),
        .bus_addr_o  (bus_addr_o),
        .bus_sel_o   (bus_sel_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_ack_i   (bus_ack_i),
        .bus_rdata_i (bus_rdata_i),
        .err_o       (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a new access request.
    task automatic drive_req(input logic we, input logic [31:0] addr,
                             input logic [3:0] sel, input logic [31:0] data);
        mem_ce_i   = 1'b1;
        mem_we_i   = we;
        mem_addr_i = addr;
        mem_sel_i  = sel;
        mem_data_i = data;
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        rst         = 1'b0;
        mem_ce_i    = 1'b0;
        mem_we_i    = 1'b0;
        mem_addr_i  = '0;
        mem_sel_i   = '0;
        mem_data_i  = '0;
        stall_i     = 1'b0;
        flush_i     = 1'b0;
        bus_ack_i   = 1'b0;
        bus_rdata_i = '0;

        // ---------------- reset state ----------------
        step();
        step();
        #1;
        check_val("rst_bus_req",  32'(bus_req_o),  32'd0);
        check_val("rst_stallreq", 32'(stallreq_o), 32'd0);
        check_val("rst_mem_data", mem_data_o,      32'd0);
        check_val("rst_err",      32'(err_o),      32'd0);
        check_val("rst_bus_addr", bus_addr_o,      32'd0);
        step();
        rst = 1'b1;

        // ---------------- read, zero wait ----------------
        drive_req(1'b0, 32'h0000_0100, 4'b1111, 32'h0);
        #1;
        check_val("rd0_idle_stall", 32'(stallreq_o), 32'd1);
        check_val("rd0_idle_req",   32'(bus_req_o),  32'd0);
        step();
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'hDEAD_BEEF;
        #1;
        check_val("rd0_bus_req",   32'(bus_req_o),  32'd1);
        check_val("rd0_bus_addr",  bus_addr_o,      32'h0000_0100);
        check_val("rd0_bus_we",    32'(bus_we_o),   32'd0);
        check_val("rd0_bus_stall", 32'(stallreq_o), 32'd1);
        step();
        bus_ack_i = 1'b0;
        #1;
        check_val("rd0_done_req",   32'(bus_req_o),  32'd0);
        check_val("rd0_done_stall", 32'(stallreq_o), 32'd0);
        check_val("rd0_done_data",  mem_data_o,      32'hDEAD_BEEF);
        step();
        mem_ce_i = 1'b0;
        #1;
        check_val("rd0_idle2_stall", 32'(stallreq_o), 32'd0);
        check_val("rd0_idle2_data",  mem_data_o,      32'hDEAD_BEEF);

        // ---------------- write, 3 wait states ----------------
        drive_req(1'b1, 32'h0000_0204, 4'b0011, 32'h1234_5678);
        #1;
        check_val("wr3_idle_stall", 32'(stallreq_o), 32'd1);
        step();
        for (int i = 1; i <= 4; i++) begin
            bus_ack_i = (i == 4);
            #1;
            check_val($sformatf("wr3_bus%0d_req", i),   32'(bus_req_o),  32'd1);
            check_val($sformatf("wr3_bus%0d_we", i),    32'(bus_we_o),   32'd1);
            check_val($sformatf("wr3_bus%0d_addr", i),  bus_addr_o,      32'h0000_0204);
            check_val($sformatf("wr3_bus%0d_sel", i),   32'(bus_sel_o),  32'h3);
            check_val($sformatf("wr3_bus%0d_wdata", i), bus_wdata_o,     32'h1234_5678);
            check_val($sformatf("wr3_bus%0d_stall", i), 32'(stallreq_o), 32'd1);
            step();
        end
        bus_ack_i = 1'b0;
        #1;
        check_val("wr3_done_req",   32'(bus_req_o),  32'd0);
        check_val("wr3_done_stall", 32'(stallreq_o), 32'd0);
        check_val("wr3_done_data",  mem_data_o,      32'hDEAD_BEEF);
        check_val("wr3_done_err",   32'(err_o),      32'd0);
        step();
        mem_ce_i = 1'b0;

        // ---------------- timeout (TIMEOUT=4) ----------------
        drive_req(1'b0, 32'h0000_0300, 4'b1111, 32'h0);
        step();
        for (int i = 1; i <= 4; i++) begin
            #1;
            check_val($sformatf("to_bus%0d_req", i),   32'(bus_req_o),  32'd1);
            check_val($sformatf("to_bus%0d_err", i),   32'(err_o),      32'd0);
            check_val($sformatf("to_bus%0d_stall", i), 32'(stallreq_o), 32'd1);
            step();
        end
        #1;
        check_val("to_done_req",   32'(bus_req_o),  32'd0);
        check_val("to_done_err",   32'(err_o),      32'd1);
        check_val("to_done_data",  mem_data_o,      32'd0);
        check_val("to_done_stall", 32'(stallreq_o), 32'd0);
        step();
        mem_ce_i = 1'b0;
        #1;
        check_val("to_idle_err", 32'(err_o),     32'd0);
        check_val("to_idle_req", 32'(bus_req_o), 32'd0);

        // ---------------- flush mid-read ----------------
        drive_req(1'b0, 32'h0000_0400, 4'b1111, 32'h0);
        step();
        #1;
        check_val("fl_bus1_req", 32'(bus_req_o), 32'd1);
        step();
        flush_i = 1'b1;
        #1;
        check_val("fl_bus2_stall", 32'(stallreq_o), 32'd1);
        step();
        flush_i     = 1'b0;
        mem_ce_i    = 1'b0;
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'hAAAA_5555;
        #1;
        check_val("fl_bus3_req",   32'(bus_req_o),  32'd1);
        check_val("fl_bus3_stall", 32'(stallreq_o), 32'd1);
        step();
        bus_ack_i = 1'b0;
        // A new request here is only stalled on if the bridge is in IDLE.
        drive_req(1'b0, 32'h0000_0500, 4'b1111, 32'h0);
        #1;
        check_val("fl_after_stall", 32'(stallreq_o), 32'd1);
        check_val("fl_after_req",   32'(bus_req_o),  32'd0);
        check_val("fl_after_data",  mem_data_o,      32'd0);
        step();
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'h0BAD_F00D;
        #1;
        check_val("rd5_bus_addr", bus_addr_o,     32'h0000_0500);
        check_val("rd5_bus_req",  32'(bus_req_o), 32'd1);
        step();
        bus_ack_i = 1'b0;

        // ---------------- held in DONE ----------------
        stall_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) stall_i = 1'b0;
            #1;
            check_val($sformatf("hd%0d_req", i),   32'(bus_req_o),  32'd0);
            check_val($sformatf("hd%0d_stall", i), 32'(stallreq_o), 32'd0);
            check_val($sformatf("hd%0d_data", i),  mem_data_o,      32'h0BAD_F00D);
            step();
        end
        mem_ce_i = 1'b0;
        #1;
        check_val("hd_idle_req",   32'(bus_req_o),  32'd0);
        check_val("hd_idle_stall", 32'(stallreq_o), 32'd0);

        // ---------------- async reset and sel=0000 ----------------
        drive_req(1'b0, 32'h0000_0600, 4'b1111, 32'h0);
        step();
        #1;
        check_val("ar_bus_req", 32'(bus_req_o), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_val("ar_req",   32'(bus_req_o),  32'd0);
        check_val("ar_addr",  bus_addr_o,      32'd0);
        check_val("ar_data",  mem_data_o,      32'd0);
        check_val("ar_stall", 32'(stallreq_o), 32'd0);
        check_val("ar_err",   32'(err_o),      32'd0);
        step();
        rst = 1'b1;
        drive_req(1'b0, 32'h0000_0700, 4'b0000, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val($sformatf("sel0_%0d_stall", i), 32'(stallreq_o), 32'd0);
            check_val($sformatf("sel0_%0d_req", i),   32'(bus_req_o),  32'd0);
            step();
        end
        mem_ce_i = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
